cache_data_arbiter: RTL and testbench

//  Shares one cache_data instance (1 read port, 1 write port) between NUM_REQ read requesters and one line-fill source.

---
 rtl/cache_data_arbiter.sv | 131 +++++++++++++
 tb/tb_cache_data_arbiter.sv | 501 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_data_arbiter.sv
// Round-robin read arbiter plus fill path in front of a single-read/single-write cache_data.
// A read yields to a same-line fill until it has been deferred STARVE_LIMIT times in a row.
module cache_data_arbiter #(
    parameter int NUM_REQ          = 2,
    parameter int NUM_WAYS         = 4,
    parameter int NUM_SETS         = 16,
    parameter int CACHE_LINE_BYTES = 64,
    parameter int STARVE_LIMIT     = 4,
    localparam int CACHE_LINE_BITS = CACHE_LINE_BYTES * 8,
    localparam int NUM_WAYS_LOG    = $clog2(NUM_WAYS),
    localparam int NUM_SETS_LOG    = $clog2(NUM_SETS),
    localparam int REQ_ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*NUM_WAYS_LOG-1:0] req_way_idx,
    input  logic [NUM_REQ*NUM_SETS_LOG-1:0] req_set_idx,
    input  logic                            fill_valid,
    output logic                            fill_ready,
    input  logic [NUM_WAYS_LOG-1:0]         fill_way_idx,
    input  logic [NUM_SETS_LOG-1:0]         fill_set_idx,
    input  logic [CACHE_LINE_BITS-1:0]      fill_data,
    output logic                            access_en,
    output logic [NUM_WAYS_LOG-1:0]         access_way_idx,
    output logic [NUM_SETS_LOG-1:0]         access_set_idx,
    input  logic [CACHE_LINE_BITS-1:0]      access_data,
    output logic                            update_en,
    output logic [NUM_WAYS_LOG-1:0]         update_way_idx,
    output logic [NUM_SETS_LOG-1:0]         update_set_idx,
    output logic [CACHE_LINE_BITS-1:0]      update_data,
    output logic                            resp_valid,
    output logic [REQ_ID_W-1:0]             resp_id,
    output logic [CACHE_LINE_BITS-1:0]      resp_data
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [REQ_ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [STARVE_W-1:0]     starve_cnt_q, starve_cnt_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [REQ_ID_W-1:0]     resp_id_q, resp_id_d;

    logic                    cand_found;
    logic [REQ_ID_W-1:0]     cand_idx;
    logic [NUM_WAYS_LOG-1:0] cand_way;
    logic [NUM_SETS_LOG-1:0] cand_set;
    logic                    hazard;
    logic                    starved;
    logic                    read_win;
    logic                    fill_win;

    // Scan from the highest offset down so the nearest requester at/after rr_ptr wins.
    always_comb begin : cand_search
        int j;
        j          = 0;
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(rr_ptr_q) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (req_valid[j]) begin
                cand_found = 1'b1;
                cand_idx   = REQ_ID_W'(j);
            end
        end
    end

    always_comb begin
        cand_way = req_way_idx[int'(cand_idx)*NUM_WAYS_LOG +: NUM_WAYS_LOG];
        cand_set = req_set_idx[int'(cand_idx)*NUM_SETS_LOG +: NUM_SETS_LOG];
        hazard   = fill_valid && cand_found &&
                   (cand_set == fill_set_idx) && (cand_way == fill_way_idx);
        starved  = (starve_cnt_q == STARVE_MAX);
        read_win = rst_n && cand_found && (!hazard || starved);
        fill_win = rst_n && fill_valid && !(hazard && starved);
    end

    always_comb begin
        req_ready = '0;
        if (read_win) begin
            req_ready[cand_idx] = 1'b1;
        end
        access_en      = read_win;
        access_way_idx = cand_way;
        access_set_idx = cand_set;

        fill_ready     = fill_win;
        update_en      = fill_win;
        update_way_idx = fill_way_idx;
        update_set_idx = fill_set_idx;
        update_data    = fill_data;
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        starve_cnt_d = starve_cnt_q;
        if (read_win) begin
            rr_ptr_d     = (int'(cand_idx) == NUM_REQ - 1) ? '0 : cand_idx + REQ_ID_W'(1);
            starve_cnt_d = '0;
        end else if (hazard) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
        resp_valid_d = read_win;
        resp_id_d    = read_win ? cand_idx : resp_id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            starve_cnt_q <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
        end
    end

    // cache_data returns the line one cycle after access_en, lining up with resp_valid.
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_valid_q ? access_data : '0;

endmodule

// File: tb/tb_cache_data_arbiter.sv
// Bench for cache_data_arbiter: cache_data model, response scoreboard and directed scenarios.
module tb_cache_data_arbiter;

    localparam int NR    = 2;
    localparam int NW    = 4;
    localparam int NS    = 16;
    localparam int LB    = 64;
    localparam int LBITS = LB * 8;
    localparam int SL    = 4;
    localparam int WL    = 2;
    localparam int SLG   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*WL-1:0]  req_way_idx;
    logic [NR*SLG-1:0] req_set_idx;
    logic              fill_valid;
    logic              fill_ready;
    logic [WL-1:0]     fill_way_idx;
    logic [SLG-1:0]    fill_set_idx;
    logic [LBITS-1:0]  fill_data;
    logic              access_en;
    logic [WL-1:0]     access_way_idx;
    logic [SLG-1:0]    access_set_idx;
    logic [LBITS-1:0]  access_data;
    logic              update_en;
    logic [WL-1:0]     update_way_idx;
    logic [SLG-1:0]    update_set_idx;
    logic [LBITS-1:0]  update_data;
    logic              resp_valid;
    logic [0:0]        resp_id;
    logic [LBITS-1:0]  resp_data;

    logic           rv [NR];
    logic [WL-1:0]  rw [NR];
    logic [SLG-1:0] rs [NR];

    always_comb begin
        req_valid   = '0;
        req_way_idx = '0;
        req_set_idx = '0;
        for (int k = 0; k < NR; k++) begin
            req_valid[k]               = rv[k];
            req_way_idx[k*WL +: WL]    = rw[k];
            req_set_idx[k*SLG +: SLG]  = rs[k];
        end
    end

    cache_data_arbiter #(
        .NUM_REQ(NR), .NUM_WAYS(NW), .NUM_SETS(NS),
        .CACHE_LINE_BYTES(LB), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_way_idx(req_way_idx), .req_set_idx(req_set_idx),
        .fill_valid(fill_valid), .fill_ready(fill_ready),
        .fill_way_idx(fill_way_idx), .fill_set_idx(fill_set_idx), .fill_data(fill_data),
        .access_en(access_en), .access_way_idx(access_way_idx),
        .access_set_idx(access_set_idx), .access_data(access_data),
        .update_en(update_en), .update_way_idx(update_way_idx),
        .update_set_idx(update_set_idx), .update_data(update_data),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [0:0]       id;
        logic [LBITS-1:0] data;
    } exp_t;
    exp_t sbq[$];

    // dev_mem is the cache_data model driven by the DUT; ref_mem is what the bench expects it to hold.
    logic [LBITS-1:0] dev_mem [NS*NW];
    logic [LBITS-1:0] ref_mem [NS*NW];

    function automatic logic [LBITS-1:0] init_line(int s, int w);
        logic [31:0] x;
        x = 32'hA000_0000 | 32'(s << 8) | 32'(w);
        return {16{x}};
    endfunction

    function automatic logic [LBITS-1:0] fill_line(int k);
        logic [31:0] x;
        x = 32'hF000_0000 | 32'(k);
        return {16{x}};
    endfunction

    logic             cap_grant, cap_fill, cap_acc_en, cap_upd_en;
    logic [0:0]       cap_id;
    int               cap_gline, cap_fline, cap_acc_line, cap_upd_line;
    logic [LBITS-1:0] cap_fdata, cap_upd_data;

    always @(negedge clk) begin
        int gcount;
        int gid;
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_resp_valid: got %b expected 0", resp_valid);
            end
            cap_grant  = 1'b0;
            cap_fill   = 1'b0;
            cap_acc_en = 1'b0;
            cap_upd_en = 1'b0;
        end else begin
            if (resp_valid === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: resp_valid=1 with no outstanding grant");
                end else begin
                    e = sbq.pop_front();
                    if (resp_id !== e.id || resp_data !== e.data) begin
                        errors++;
                        $display("FAIL resp_match: id=%0d data=%h expected id=%0d data=%h",
                                 resp_id, resp_data[63:0], e.id, e.data[63:0]);
                    end
                end
            end else if (sbq.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL resp_missing: resp_valid=%b expected 1", resp_valid);
                void'(sbq.pop_front());
            end

            gcount = 0;
            gid    = 0;
            for (int k = 0; k < NR; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    gcount++;
                    gid = k;
                end
            end
            checks++;
            if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) begin
                errors++;
                $display("FAIL ready_onehot: req_ready=%b req_valid=%b", req_ready, req_valid);
            end
            checks++;
            if (access_en !== (gcount == 1)) begin
                errors++;
                $display("FAIL access_en: got %b expected %b", access_en, (gcount == 1));
            end
            if (gcount == 1) begin
                checks++;
                if (access_set_idx !== rs[gid] || access_way_idx !== rw[gid]) begin
                    errors++;
                    $display("FAIL access_idx: got set=%0d way=%0d expected set=%0d way=%0d",
                             access_set_idx, access_way_idx, rs[gid], rw[gid]);
                end
            end
            checks++;
            if (update_en !== (fill_valid && fill_ready) || (fill_ready && !fill_valid)) begin
                errors++;
                $display("FAIL update_en: got %b fill_ready=%b fill_valid=%b",
                         update_en, fill_ready, fill_valid);
            end
            if (update_en === 1'b1) begin
                checks++;
                if (update_set_idx !== fill_set_idx || update_way_idx !== fill_way_idx ||
                    update_data !== fill_data) begin
                    errors++;
                    $display("FAIL update_fields: got set=%0d way=%0d expected set=%0d way=%0d",
                             update_set_idx, update_way_idx, fill_set_idx, fill_way_idx);
                end
            end

            cap_grant    = (gcount == 1);
            cap_id       = gid[0:0];
            cap_gline    = int'(rs[gid]) * NW + int'(rw[gid]);
            cap_fill     = fill_valid && fill_ready;
            cap_fline    = int'(fill_set_idx) * NW + int'(fill_way_idx);
            cap_fdata    = fill_data;
            cap_acc_en   = access_en;
            cap_acc_line = int'(access_set_idx) * NW + int'(access_way_idx);
            cap_upd_en   = update_en;
            cap_upd_line = int'(update_set_idx) * NW + int'(update_way_idx);
            cap_upd_data = update_data;
        end
    end

    always @(posedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (cap_acc_en) access_data <= dev_mem[cap_acc_line];
            if (cap_upd_en) dev_mem[cap_upd_line] = cap_upd_data;
            if (cap_grant) begin
                e.id   = cap_id;
                e.data = ref_mem[cap_gline];
                sbq.push_back(e);
            end
            if (cap_fill) ref_mem[cap_fline] = cap_fdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < NR; k++) rv[k] = 1'b0;
        fill_valid = 1'b0;
    endtask

    task automatic set_req(int k, int s, int w);
        rv[k] = 1'b1;
        rs[k] = SLG'(s);
        rw[k] = WL'(w);
    endtask

    task automatic set_fill(int s, int w, int k);
        fill_valid   = 1'b1;
        fill_set_idx = SLG'(s);
        fill_way_idx = WL'(w);
        fill_data    = fill_line(k);
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_req(0, 1, 1);
        set_req(1, 2, 2);
        set_fill(7, 3, 100);
        repeat (3) begin
            tick();
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_hold_resp: got %b expected 0", resp_valid);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01 || fill_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_first_grant: req_ready=%b fill_ready=%b expected 01 1", req_ready, fill_ready);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0) begin
            errors++;
            $display("FAIL rst_first_resp: valid=%b id=%0d expected 1 0", resp_valid, resp_id);
        end
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL rst_rr_advance: req_ready=%b expected 10", req_ready);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_rdy;
        apply_reset();
        set_req(0, 0, 0);
        set_req(1, 1, 1);
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_grant[%0d]: req_ready=%b expected %b", i, req_ready, exp_rdy);
            end
            tick();
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== 1'((i % 2))) begin
                errors++;
                $display("FAIL rr_resp_id[%0d]: valid=%b id=%0d expected 1 %0d", i, resp_valid, resp_id, i % 2);
            end
        end
        clear_inputs();
    endtask

    task automatic test_parallel();
        apply_reset();
        set_req(0, 3, 2);
        set_fill(5, 1, 200);
        #1;
        checks++;
        if (access_en !== 1'b1 || update_en !== 1'b1 || access_set_idx !== 4'd3 ||
            access_way_idx !== 2'd2 || update_set_idx !== 4'd5 || update_way_idx !== 2'd1) begin
            errors++;
            $display("FAIL par_issue: acc=%b upd=%b aset=%0d away=%0d uset=%0d uway=%0d expected 1 1 3 2 5 1",
                     access_en, update_en, access_set_idx, access_way_idx, update_set_idx, update_way_idx);
        end
        tick();
        fill_valid = 1'b0;
        set_req(0, 5, 1);
        checks++;
        if (resp_data !== init_line(3, 2)) begin
            errors++;
            $display("FAIL par_old_line: got %h expected %h", resp_data[63:0], init_line(3, 2) & 64'hFFFF_FFFF_FFFF_FFFF);
        end
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL par_regrant: req_ready=%b expected 01", req_ready);
        end
        tick();
        clear_inputs();
        checks++;
        if (resp_data !== fill_line(200)) begin
            errors++;
            $display("FAIL par_filled_line: got %h expected %h", resp_data[63:0], fill_line(200) & 64'hFFFF_FFFF_FFFF_FFFF);
        end
    endtask

    task automatic test_starvation();
        apply_reset();
        set_req(0, 3, 2);
        set_fill(3, 2, 301);
        for (int k = 1; k <= SL; k++) begin
            fill_data = fill_line(300 + k);
            #1;
            checks++;
            if (req_ready !== 2'b00 || access_en !== 1'b0 || fill_ready !== 1'b1 || update_en !== 1'b1) begin
                errors++;
                $display("FAIL starve_fill_wins[%0d]: rdy=%b acc=%b frdy=%b upd=%b expected 00 0 1 1",
                         k, req_ready, access_en, fill_ready, update_en);
            end
            tick();
        end
        fill_data = fill_line(305);
        #1;
        checks++;
        if (req_ready !== 2'b01 || fill_ready !== 1'b0 || update_en !== 1'b0) begin
            errors++;
            $display("FAIL starve_read_wins: rdy=%b frdy=%b upd=%b expected 01 0 0", req_ready, fill_ready, update_en);
        end
        tick();
        rv[0] = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== fill_line(304)) begin
            errors++;
            $display("FAIL starve_resp_data: valid=%b got %h expected %h", resp_valid, resp_data[63:0],
                     fill_line(304) & 64'hFFFF_FFFF_FFFF_FFFF);
        end
        #1;
        checks++;
        if (fill_ready !== 1'b1) begin
            errors++;
            $display("FAIL starve_fill_resume: fill_ready=%b expected 1", fill_ready);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_single_hazard();
        apply_reset();
        set_req(0, 4, 0);
        set_fill(4, 0, 400);
        #1;
        checks++;
        if (req_ready !== 2'b00 || fill_ready !== 1'b1) begin
            errors++;
            $display("FAIL hz_fill_first: rdy=%b frdy=%b expected 00 1", req_ready, fill_ready);
        end
        tick();
        fill_valid = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b01 || access_en !== 1'b1) begin
            errors++;
            $display("FAIL hz_read_next: rdy=%b acc=%b expected 01 1", req_ready, access_en);
        end
        tick();
        clear_inputs();
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== fill_line(400)) begin
            errors++;
            $display("FAIL hz_new_data: valid=%b got %h expected %h", resp_valid, resp_data[63:0],
                     fill_line(400) & 64'hFFFF_FFFF_FFFF_FFFF);
        end
    endtask

    task automatic test_noncand_fill();
        apply_reset();
        set_req(0, 1, 1);
        set_req(1, 2, 2);
        set_fill(2, 2, 500);
        #1;
        checks++;
        if (req_ready !== 2'b01 || fill_ready !== 1'b1) begin
            errors++;
            $display("FAIL nc_both_go: rdy=%b frdy=%b expected 01 1", req_ready, fill_ready);
        end
        tick();
        fill_valid = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL nc_next_grant: rdy=%b expected 10", req_ready);
        end
        tick();
        clear_inputs();
        checks++;
        if (resp_id !== 1'b1 || resp_data !== fill_line(500)) begin
            errors++;
            $display("FAIL nc_resp: id=%0d got %h expected 1 %h", resp_id, resp_data[63:0],
                     fill_line(500) & 64'hFFFF_FFFF_FFFF_FFFF);
        end
    endtask

    task automatic test_reset_inflight();
        apply_reset();
        set_req(0, 6, 3);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rif_grant: rdy=%b expected 01", req_ready);
        end
        tick();
        rst_n = 1'b0;
        set_req(1, 7, 0);
        #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rif_drop: resp_valid=%b expected 0", resp_valid);
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rif_rr_cleared: rdy=%b expected 01", req_ready);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                dev_mem[s*NW + w] = init_line(s, w);
                ref_mem[s*NW + w] = init_line(s, w);
            end
        end
        access_data  = '0;
        fill_data    = '0;
        fill_set_idx = '0;
        fill_way_idx = '0;
        for (int k = 0; k < NR; k++) begin
            rv[k] = 1'b0;
            rs[k] = '0;
            rw[k] = '0;
        end
        fill_valid = 1'b0;

        test_reset();
        test_round_robin();
        test_parallel();
        test_starvation();
        test_single_hazard();
        test_noncand_fill();
        test_reset_inflight();
        tick();
        tick();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d responses outstanding expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
